bch_syndrome_serial: RTL

- Serial syndrome generator for binary BCH decoding over GF(2^M).
- Accepts one received codeword bit per handshake, MSB (x^(N-1) coefficient) first.
- Evaluates S_j = r(alpha^j) for j = 1..2T by Horner's rule, one lane per syndrome.
- Each lane multiplies by constant alpha^j through a constant GF matrix multiply.
- Sits directly upstream of the error-locator stage, which consumes the packed syndrome vector.

---
 rtl/bch_gf_pkg.sv | 57 +++++
 rtl/bch_syndrome_lane.sv | 36 +++
 rtl/bch_syndrome_serial.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bch_gf_pkg.sv
// GF(2^M) helpers shared by the BCH syndrome blocks: default primitive
// polynomials, constant alpha^k multiply matrices and packed syndrome width.
package bch_gf_pkg;

  localparam int MAXM = 16;

  typedef logic [MAXM-1:0] gf_elem_t;
  typedef gf_elem_t [MAXM-1:0] gf_mat_t;

  typedef enum logic {ST_ACCUM, ST_HOLD} syn_state_e;

  // Primitive polynomial for GF(2^m), x^m term omitted.
  function automatic gf_elem_t default_poly(input int m);
    case (m)
      2, 3, 4, 6, 7, 15: return 16'h0003;
      5, 11:             return 16'h0005;
      8:                 return 16'h001D;
      9:                 return 16'h0011;
      10:                return 16'h0009;
      12:                return 16'h0053;
      13:                return 16'h001B;
      14:                return 16'h0443;
      16:                return 16'h100B;
      default:           return 16'h0003;
    endcase
  endfunction

  // Multiply an element by alpha (x) modulo the field polynomial.
  function automatic gf_elem_t gf_mulx(input gf_elem_t v, input int m, input gf_elem_t poly);
    gf_elem_t r;
    logic     msb;
    msb = v[m-1];
    r   = v << 1;
    if (msb) r = r ^ poly;
    for (int i = m; i < MAXM; i++) r[i] = 1'b0;
    return r;
  endfunction

  // Column i holds alpha^(i+k): the image of basis element alpha^i under *alpha^k.
  function automatic gf_mat_t gf_alpha_mat(input int k, input int m, input gf_elem_t poly);
    gf_mat_t  mt;
    gf_elem_t e;
    mt = '0;
    for (int i = 0; i < m; i++) begin
      e    = '0;
      e[i] = 1'b1;
      for (int s = 0; s < k; s++) e = gf_mulx(e, m, poly);
      mt[i] = e;
    end
    return mt;
  endfunction

  function automatic int syn_width(input int m, input int t);
    return 2 * t * m;
  endfunction

endpackage

// File: rtl/bch_syndrome_lane.sv
// One Horner lane: S <= S*alpha^K ^ bit, with the previous value forced to 0
// on the first bit of a frame.
module bch_syndrome_lane
  import bch_gf_pkg::*;
#(
  parameter int           M    = 4,
  parameter int           K    = 1,
  parameter logic [M-1:0] POLY = M'(3)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         first,
  input  logic         bit_in,
  output logic [M-1:0] s_d,
  output logic [M-1:0] s_q
);

  localparam gf_mat_t MAT = gf_alpha_mat(K, M, MAXM'(POLY));

  logic [M-1:0] prod;

  always_comb begin
    prod = '0;
    for (int i = 0; i < M; i++)
      if (s_q[i]) prod = prod ^ MAT[i][M-1:0];
    s_d = s_q;
    if (en) s_d = (first ? '0 : prod) ^ {{(M-1){1'b0}}, bit_in};
  end

  always_ff @(posedge clk) begin
    if (reset) s_q <= '0;
    else       s_q <= s_d;
  end

endmodule

// File: rtl/bch_syndrome_serial.sv
// Serial BCH syndrome generator: one received bit per accept, MSB first, 2T lanes.
// Optional macro BCH_SYN_ERRFLAG_EN adds a registered err_detect output.
module bch_syndrome_serial
  import bch_gf_pkg::*;
#(
  parameter int          M    = 4,
  parameter int          T    = 2,
  parameter int unsigned POLY = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_data,
  output logic                       syn_valid,
  input  logic                       syn_ready,
  output logic [syn_width(M,T)-1:0]  syndromes
`ifdef BCH_SYN_ERRFLAG_EN
  ,
  output logic                       err_detect
`endif
);

  localparam int           N        = (1 << M) - 1;
  localparam int           CW       = $clog2(N + 1);
  localparam int           SW       = syn_width(M, T);
  localparam logic [M-1:0] POLY_EFF = (POLY == 0) ? M'(default_poly(M)) : M'(POLY);
  localparam logic [CW-1:0] LAST    = CW'(N - 1);

  syn_state_e    state_q;
  logic [CW-1:0] count_q;
  logic          in_ready_q;
  logic          syn_valid_q;
  logic          accept;
  logic          first;
  logic [SW-1:0] syn_d;
  logic [SW-1:0] syn_q;

  assign accept = in_valid & in_ready_q;
  assign first  = (count_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ACCUM;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      syn_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            if (count_q == LAST) begin
              count_q     <= '0;
              state_q     <= ST_HOLD;
              in_ready_q  <= 1'b0;
              syn_valid_q <= 1'b1;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // Next frame may start only once the hold has been released.
          if (syn_ready) begin
            state_q     <= ST_ACCUM;
            syn_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

  for (genvar j = 1; j <= 2 * T; j++) begin : g_lane
    bch_syndrome_lane #(
      .M    (M),
      .K    (j),
      .POLY (POLY_EFF)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .en     (accept),
      .first  (first),
      .bit_in (in_data),
      .s_d    (syn_d[M*(j-1) +: M]),
      .s_q    (syn_q[M*(j-1) +: M])
    );
  end

  assign in_ready  = in_ready_q;
  assign syn_valid = syn_valid_q;
  assign syndromes = syn_q;

`ifdef BCH_SYN_ERRFLAG_EN
  logic last;
  logic err_d;
  logic err_q;

  assign last = accept && (count_q == LAST);

  // Sampled from the final lane update so it lands together with syn_valid.
  always_comb begin
    err_d = err_q;
    if (last) err_d = |syn_d;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_detect = err_q;
`else
  logic unused_syn_d;
  assign unused_syn_d = ^syn_d;
`endif

endmodule
